// File: rtl/ga_pkg.sv
// Shared constants and types for the GA mutation-path blocks.
// Holds the datapath sizing and the state encoding of the mutation input arbiter.
package ga_pkg;

  localparam int DATA_W      = 6;
  localparam int M_MAX       = 32;
  localparam int P_MAX       = 1024;
  localparam int CHROM_MAX_W = DATA_W * M_MAX;
  localparam int P_MAX_W     = $clog2(P_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } ga_mut_arb_st_t;

endpackage

// File: rtl/ga_mutation_arb_if.sv
// Bundle between the two crossover units, the mutation datapath,
// the generation sequencer and the mutation input arbiter.
// master: the arbiter side; slave: everything around it.
interface ga_mutation_arb_if;
  import ga_pkg::*;

  logic [P_MAX_W-1:0]     cnfg_p;
  logic                   gen_start;
  logic                   child0_valid;
  logic [CHROM_MAX_W-1:0] child0;
  logic                   child0_ack;
  logic                   child1_valid;
  logic [CHROM_MAX_W-1:0] child1;
  logic                   child1_ack;
  logic                   mut_child_valid;
  logic [CHROM_MAX_W-1:0] mut_child;
  logic                   mut_child_ack;
  logic                   gen_busy;
  logic                   gen_done;
  logic [P_MAX_W-1:0]     child_cnt;

  modport master (
    input  cnfg_p, gen_start,
    input  child0_valid, child0, child1_valid, child1, mut_child_ack,
    output child0_ack, child1_ack, mut_child_valid, mut_child,
    output gen_busy, gen_done, child_cnt
  );

  modport slave (
    output cnfg_p, gen_start,
    output child0_valid, child0, child1_valid, child1, mut_child_ack,
    input  child0_ack, child1_ack, mut_child_valid, mut_child,
    input  gen_busy, gen_done, child_cnt
  );

endinterface

// File: rtl/ga_rr_arb2.sv
// Two-request arbiter used to pick which crossover unit feeds mutation next.
// Default: round-robin, the pointer moves past the source just served on
// every transfer strobe. With GA_MUT_ARB_FIXED_PRIO_EN defined, request 0
// always wins and no pointer state exists.
module ga_rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sw_rst,
  input  logic [1:0] req,
  input  logic       next,
  input  logic       served,
  output logic       grant
);

`ifdef GA_MUT_ARB_FIXED_PRIO_EN

  // Source 1 is chosen only when source 0 is not requesting.
  assign grant = req[1] & ~req[0];

  logic unused;
  assign unused = &{1'b0, clk, rstn, sw_rst, next, served};

`else

  logic rr;

  // Pointer to the preferred source; after a transfer the other source is preferred.
  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr <= 1'b0;
    end else if (sw_rst) begin
      rr <= 1'b0;
    end else if (next) begin
      rr <= ~served;
    end
  end

  // Contention goes to the pointer; a lone request wins outright.
  assign grant = (req == 2'b11) ? rr : (req[1] & ~req[0]);

`endif

endmodule

// File: rtl/ga_mutation_arb.sv
// Scheduler in front of ga_mutation: forwards children from two crossover
// units one at a time and counts them against the generation size.
// Build option: GA_MUT_ARB_FIXED_PRIO_EN selects fixed priority (source 0
// wins) instead of round-robin inside ga_rr_arb2.
module ga_mutation_arb
  import ga_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              sw_rst,
  ga_mutation_arb_if.master bus
);

  ga_mut_arb_st_t     st;
  ga_mut_arb_st_t     st_nxt;
  logic               grant_r;
  logic               arb_grant;
  logic [P_MAX_W-1:0] p_r;
  logic [P_MAX_W-1:0] cnt_r;
  logic               any_valid;
  logic               sel_valid;
  logic               xfer;
  logic               last;

  assign any_valid = bus.child0_valid | bus.child1_valid;
  assign sel_valid = grant_r ? bus.child1_valid : bus.child0_valid;
  assign xfer      = (st == HOLD) & sel_valid & bus.mut_child_ack;
  assign last      = (cnt_r + 1'b1) == p_r;

  ga_rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .sw_rst (sw_rst),
    .req    ({bus.child1_valid, bus.child0_valid}),
    .next   (xfer),
    .served (grant_r),
    .grant  (arb_grant)
  );

  // State register; soft reset overrides any transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st <= IDLE;
    end else if (sw_rst) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Next-state logic: a grant is held until its transfer completes.
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: if (bus.gen_start) st_nxt = (bus.cnfg_p == '0) ? DONE : ARB;
      ARB:  if (any_valid)     st_nxt = HOLD;
      HOLD: if (xfer)          st_nxt = last ? DONE : ARB;
      DONE:                    st_nxt = IDLE;
      default:                 st_nxt = IDLE;
    endcase
  end

  // Generation size, locked grant and forwarded-child counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_r <= 1'b0;
      p_r     <= '0;
      cnt_r   <= '0;
    end else if (sw_rst) begin
      grant_r <= 1'b0;
      p_r     <= '0;
      cnt_r   <= '0;
    end else begin
      if (st == IDLE && bus.gen_start) begin
        p_r   <= bus.cnfg_p;
        cnt_r <= '0;
      end
      if (st == ARB && any_valid) begin
        grant_r <= arb_grant;
      end
      if (xfer) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  // Outputs: the datapath mux and ack steering are only live in HOLD.
  always_comb begin
    bus.mut_child_valid = 1'b0;
    bus.mut_child       = '0;
    bus.child0_ack      = 1'b0;
    bus.child1_ack      = 1'b0;
    bus.gen_busy        = (st != IDLE);
    bus.gen_done        = (st == DONE);
    if (st == HOLD) begin
      bus.mut_child_valid = sel_valid;
      bus.mut_child       = grant_r ? bus.child1 : bus.child0;
      bus.child0_ack      = ~grant_r & bus.mut_child_ack;
      bus.child1_ack      =  grant_r & bus.mut_child_ack;
    end
  end

  assign bus.child_cnt = cnt_r;

endmodule

// File: tb/tb_ga_mutation_arb.sv
// Directed bench for ga_mutation_arb: a per-cycle vector table for
// contention and zero-size generations, plus hand-written sequences for
// reset, a single slow source, grant locking and soft reset mid-handshake.
module tb_ga_mutation_arb;
  import ga_pkg::*;

`ifdef GA_MUT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic               gs;
    logic [P_MAX_W-1:0] p;
    logic               v0;
    logic               v1;
    logic               ack;
    logic               busy;
    logic               done;
    logic               mv;
    logic               a0;
    logic               a1;
    logic [P_MAX_W-1:0] cnt;
    int                 sel;   // 0: child0 on mut_child, 1: child1, 2: zero
  } vec_t;

  logic clk;
  logic rstn;
  logic sw_rst;

  ga_mutation_arb_if bus ();

  ga_mutation_arb dut (
    .clk    (clk),
    .rstn   (rstn),
    .sw_rst (sw_rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CHROM_MAX_W-1:0] d0;
  logic [CHROM_MAX_W-1:0] d1;
  vec_t tbl[13];

  int  acks_seen;
  int  wc;
  int  x0;
  int  x1;
  int  a1n;
  int  last_x;
  bit  done_seen;
  bit  done_ok;
  logic [P_MAX_W-1:0] cnt_at_done;

  task automatic check(input string name, input logic [CHROM_MAX_W-1:0] act,
                       input logic [CHROM_MAX_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic gs, int p, logic v0, logic v1, logic ack,
                              logic busy, logic done, logic mv, logic a0,
                              logic a1, int cnt, int sel);
    vec_t v;
    v.gs = gs; v.p = P_MAX_W'(p); v.v0 = v0; v.v1 = v1; v.ack = ack;
    v.busy = busy; v.done = done; v.mv = mv; v.a0 = a0; v.a1 = a1;
    v.cnt = P_MAX_W'(cnt); v.sel = sel;
    return v;
  endfunction

  function automatic logic [CHROM_MAX_W-1:0] sel_data(int sel);
    if (sel == 0) return d0;
    if (sel == 1) return d1;
    return '0;
  endfunction

  // Runs a generation of size p with the current valids and a constant ack,
  // counting transfers per source until gen_done or the cycle budget.
  task automatic run_gen(input int p, input int budget);
    bus.gen_start = 1'b1;
    bus.cnfg_p    = P_MAX_W'(p);
    @(negedge clk);
    cyc();
    bus.gen_start = 1'b0;
    x0 = 0; x1 = 0; done_seen = 1'b0;
    for (int i = 0; i < budget && !done_seen; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      if (bus.child0_ack) x0++;
      if (bus.child1_ack) x1++;
      if (bus.gen_done) begin
        done_seen   = 1'b1;
        cnt_at_done = bus.child_cnt;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d0 = {M_MAX{6'h15}};
    d1 = {M_MAX{6'h2a}};
    bus.child0 = d0;
    bus.child1 = d1;
    bus.cnfg_p = '0;
    bus.gen_start = 1'b0;
    bus.child0_valid = 1'b1;
    bus.child1_valid = 1'b1;
    bus.mut_child_ack = 1'b1;
    sw_rst = 1'b0;
    rstn = 1'b0;

    // Contention with p=4, then gen_start while busy, then a zero-size generation.
    tbl[0]  = mk(1, 4, 1, 1, 1,  0, 0, 0, 0, 0, 0, 2);
    tbl[1]  = mk(0, 4, 1, 1, 1,  1, 0, 0, 0, 0, 0, 2);
    tbl[2]  = mk(0, 4, 1, 1, 1,  1, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 4, 1, 1, 1,  1, 0, 0, 0, 0, 1, 2);
    tbl[4]  = mk(0, 4, 1, 1, 1,  1, 0, 1, FIXED, !FIXED, 1, FIXED ? 0 : 1);
    tbl[5]  = mk(0, 4, 1, 1, 1,  1, 0, 0, 0, 0, 2, 2);
    tbl[6]  = mk(0, 4, 1, 1, 1,  1, 0, 1, 1, 0, 2, 0);
    tbl[7]  = mk(0, 4, 1, 1, 1,  1, 0, 0, 0, 0, 3, 2);
    tbl[8]  = mk(0, 4, 1, 1, 1,  1, 0, 1, FIXED, !FIXED, 3, FIXED ? 0 : 1);
    tbl[9]  = mk(1, 7, 1, 1, 1,  1, 1, 0, 0, 0, 4, 2);
    tbl[10] = mk(1, 0, 1, 1, 1,  0, 0, 0, 0, 0, 4, 2);
    tbl[11] = mk(0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 2);
    tbl[12] = mk(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 2);

    // Reset held with both valids high: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_outputs_%0d", i),
            {bus.gen_busy, bus.gen_done, bus.mut_child_valid, bus.child0_ack,
             bus.child1_ack, bus.child_cnt, bus.mut_child}, '0);
    end
    rstn = 1'b1;
    acks_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.child0_ack || bus.child1_ack || bus.mut_child_valid) acks_seen++;
    end
    check("idle_no_acks", acks_seen, 0);
    cyc();

    // Table-driven per-cycle vectors.
    for (int i = 0; i < 13; i++) begin
      bus.gen_start     = tbl[i].gs;
      bus.cnfg_p        = tbl[i].p;
      bus.child0_valid  = tbl[i].v0;
      bus.child1_valid  = tbl[i].v1;
      bus.mut_child_ack = tbl[i].ack;
      @(negedge clk);
      check($sformatf("v%0d_busy", i), bus.gen_busy, tbl[i].busy);
      check($sformatf("v%0d_done", i), bus.gen_done, tbl[i].done);
      check($sformatf("v%0d_mvalid", i), bus.mut_child_valid, tbl[i].mv);
      check($sformatf("v%0d_ack0", i), bus.child0_ack, tbl[i].a0);
      check($sformatf("v%0d_ack1", i), bus.child1_ack, tbl[i].a1);
      check($sformatf("v%0d_cnt", i), bus.child_cnt, tbl[i].cnt);
      check($sformatf("v%0d_mchild", i), bus.mut_child, sel_data(tbl[i].sel));
      cyc();
    end
    bus.gen_start = 1'b0;

    // Single source, mutation model acks three cycles after valid appears.
    bus.child0_valid = 1'b1;
    bus.child1_valid = 1'b0;
    bus.mut_child_ack = 1'b0;
    bus.gen_start = 1'b1;
    bus.cnfg_p = P_MAX_W'(5);
    @(negedge clk);
    cyc();
    bus.gen_start = 1'b0;
    wc = 0; x0 = 0; a1n = 0; last_x = -10; done_seen = 1'b0; done_ok = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      if (i > 0) cyc();
      if (bus.mut_child_valid) begin
        wc++;
        bus.mut_child_ack = (wc > 3);
      end else begin
        wc = 0;
        bus.mut_child_ack = 1'b0;
      end
      @(negedge clk);
      if (bus.child1_ack) a1n++;
      if (bus.gen_done) begin
        done_seen   = 1'b1;
        done_ok     = (last_x == i - 1);
        cnt_at_done = bus.child_cnt;
      end
      if (bus.child0_ack) begin
        x0++;
        last_x = i;
      end
    end
    check("single_done_seen", done_seen, 1'b1);
    check("single_xfers0", x0, 5);
    check("single_ack1_none", a1n, 0);
    check("single_done_timing", done_ok, 1'b1);
    check("single_cnt_at_done", cnt_at_done, P_MAX_W'(5));
    cyc();
    bus.mut_child_ack = 1'b0;
    @(negedge clk);
    check("single_busy_after", bus.gen_busy, 1'b0);
    check("single_cnt_hold", bus.child_cnt, P_MAX_W'(5));
    cyc();

    // Grant lock: source 0 held while ack is withheld and source 1 appears.
    bus.gen_start = 1'b1;
    bus.cnfg_p = P_MAX_W'(2);
    bus.child0_valid = 1'b1;
    bus.child1_valid = 1'b0;
    bus.mut_child_ack = 1'b0;
    cyc();
    bus.gen_start = 1'b0;
    cyc();
    bus.child1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("lock_mchild_%0d", i), bus.mut_child, d0);
      check($sformatf("lock_ack1_%0d", i), bus.child1_ack, 1'b0);
      cyc();
    end
    bus.mut_child_ack = 1'b1;
    @(negedge clk);
    check("lock_ack0", bus.child0_ack, 1'b1);
    cyc();
    bus.child0_valid = 1'b0;
    @(negedge clk);
    check("lock_arb_gap", bus.mut_child_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("lock_src1_data", bus.mut_child, d1);
    check("lock_src1_ack", bus.child1_ack, 1'b1);
    cyc();
    @(negedge clk);
    check("lock_done", bus.gen_done, 1'b1);
    check("lock_cnt", bus.child_cnt, P_MAX_W'(2));
    cyc();
    bus.child1_valid = 1'b0;
    bus.mut_child_ack = 1'b0;
    cyc();

    // Soft reset in HOLD after two transfers, then a fresh generation.
    bus.gen_start = 1'b1;
    bus.cnfg_p = P_MAX_W'(4);
    bus.child0_valid = 1'b1;
    bus.mut_child_ack = 1'b1;
    cyc();
    bus.gen_start = 1'b0;
    repeat (5) cyc();
    bus.mut_child_ack = 1'b0;
    sw_rst = 1'b1;
    @(negedge clk);
    check("swrst_in_hold", bus.mut_child_valid, 1'b1);
    check("swrst_cnt_before", bus.child_cnt, P_MAX_W'(2));
    cyc();
    sw_rst = 1'b0;
    @(negedge clk);
    check("swrst_busy", bus.gen_busy, 1'b0);
    check("swrst_cnt", bus.child_cnt, '0);
    check("swrst_no_ack", {bus.child0_ack, bus.child1_ack}, '0);
    cyc();
    bus.mut_child_ack = 1'b1;
    run_gen(4, 100);
    check("swrst_regen_done", done_seen, 1'b1);
    check("swrst_regen_xfers", x0, 4);
    check("swrst_regen_cnt", cnt_at_done, P_MAX_W'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
